count_seq_ctrl: RTL and testbench
=================================

COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 Parameter N, default 8, counter width in bits.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  controller accepts a command this cycle.
REQ-006 cmd_start  in  N  counter load value for each pass.
REQ-007 cmd_end  in  N  terminal value ending each pass.
REQ-008 cmd_up  in  1  1 = count up, 0 = count down.
REQ-009 cmd_reps  in  4  extra passes after the first; total passes = cmd_reps+1.
REQ-010 abort  in  1  cancel the active command.
REQ-011 ctr_syn_clr, ctr_load, ctr_en, ctr_up  out  1 each  controls to the external universal counter.
REQ-012 ctr_d  out  N  load data to the counter.
REQ-013 ctr_q  in  N  counter registered value, updated on the clk edge following the control.
REQ-014 ctr_max_tick, ctr_min_tick  in  1 each  counter at all-ones / zero.
REQ-015 busy  out  1  command in progress.
REQ-016 done  out  1  one-cycle pulse at normal completion.
REQ-017 aborted  out  1  one-cycle pulse at abort completion.
REQ-018 wrapped  out  1  sticky; counter wrapped during the current or last command.
REQ-019 pass_cnt  out  4  number of completed passes of the current or last command.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, RUN, DONE, ABORT; all outputs SHALL be decoded from registered state and latched command registers.
REQ-021 IDLE: cmd_ready=1, busy=0, all ctr_* controls 0; on cmd_valid&cmd_ready: latch start/end/up/reps, clear wrapped and pass_cnt, go LOAD.
REQ-022 cmd_ready SHALL be 0 in every state except IDLE; commands offered then SHALL be ignored.
REQ-023 LOAD (exactly 1 cycle): ctr_load=1, ctr_d=latched start, ctr_en=0; next state RUN.
REQ-024 RUN: ctr_up=latched up; if ctr_q==latched end, ctr_en=0 and the pass ends, else ctr_en=1.
REQ-025 At pass end: pass_cnt increments (saturating at 15); if reps remaining = 0, go DONE, else decrement reps remaining and go LOAD.
REQ-026 start==end SHALL yield a zero-step pass: one RUN cycle with ctr_en never asserted.
REQ-027 Step count per pass SHALL be (end-start) mod 2^N counting up, (start-end) mod 2^N counting down; wrap-around through all-ones/zero is legal.
REQ-028 wrapped SHALL be set when, in RUN with ctr_en=1, up=1 and ctr_max_tick=1, or up=0 and ctr_min_tick=1.
REQ-029 DONE (1 cycle): done=1, busy=0, next state IDLE.
REQ-030 abort in LOAD or RUN SHALL take priority over pass end: next state ABORT; abort in IDLE or DONE SHALL be ignored.
REQ-031 ABORT (1 cycle): ctr_syn_clr=1, ctr_en=0, ctr_load=0, aborted=1; next state IDLE; pass_cnt and wrapped hold.
REQ-032 busy SHALL be 1 in LOAD and RUN only; ctr_syn_clr SHALL be 1 only in ABORT; ctr_load SHALL be 1 only in LOAD.
REQ-033 Latency: handshake at cycle t gives LOAD at t+1 and first RUN at t+2; each pass takes 2+steps cycles; done follows the final pass-end cycle by one cycle.

Reset
REQ-034 Reset SHALL force IDLE, all ctr_* outputs 0, ctr_d=0, busy=done=aborted=wrapped=0, pass_cnt=0, latched command 0, cmd_ready=1 after release.
REQ-035 Reset asserted mid-command SHALL drop the command with no done or aborted pulse.

Verification
REQ-036 N=8, start=3, end=6, up=1, reps=0, accepted cycle 0 -> ctr_load cycle 1; ctr_q 3,4,5,6 over cycles 2-5; done=1 cycle 6; cmd_ready=1 cycle 7; pass_cnt=1; wrapped=0.
REQ-037 start=254, end=1, up=1 -> ctr_q 254,255,0,1; wrapped=1 after the 255 cycle; done after 3 steps.
REQ-038 start=5, end=2, up=0, reps=2 -> three LOAD pulses, each followed by ctr_q 5,4,3,2; done once; pass_cnt=3.
REQ-039 start=end=7 -> single RUN cycle with ctr_en=0; done 3 cycles after handshake.
REQ-040 abort asserted at the ctr_q==end cycle of pass 1 of reps=1 -> ABORT next cycle with ctr_syn_clr=1, aborted=1, no done; pass_cnt=0; IDLE after.
REQ-041 reset asserted during RUN -> all outputs at reset values immediately; cmd_valid held during busy is accepted only after return to IDLE.

Source files
------------

// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - sequencing controller driving an external universal counter
//
// Accepts a command (start, end, direction, repeat count) and steps an
// external counter from start to end once per pass, reloading between
// passes. Reports completion, abort, wrap-around and completed pass count.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cmd_valid / cmd_ready       command handshake
//   cmd_start, cmd_end          per-pass load value and terminal value
//   cmd_up, cmd_reps            direction and extra passes after the first
//   abort                       cancel the active command
//   ctr_syn_clr, ctr_load,
//   ctr_en, ctr_up, ctr_d       controls and load data to the counter
//   ctr_q, ctr_max_tick,
//   ctr_min_tick                counter value and all-ones / zero flags
//   busy, done, aborted         status (done/aborted are one-cycle pulses)
//   wrapped, pass_cnt           sticky wrap flag and completed pass count
module count_seq_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_start,
  input  logic [N-1:0] cmd_end,
  input  logic         cmd_up,
  input  logic [3:0]   cmd_reps,
  input  logic         abort,
  output logic         ctr_syn_clr,
  output logic         ctr_load,
  output logic         ctr_en,
  output logic         ctr_up,
  output logic [N-1:0] ctr_d,
  input  logic [N-1:0] ctr_q,
  input  logic         ctr_max_tick,
  input  logic         ctr_min_tick,
  output logic         busy,
  output logic         done,
  output logic         aborted,
  output logic         wrapped,
  output logic [3:0]   pass_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] start_q, start_d;
  logic [N-1:0] end_q, end_d;
  logic         up_q, up_d;
  logic [3:0]   reps_q, reps_d;
  logic         wrapped_q, wrapped_d;
  logic [3:0]   pass_cnt_q, pass_cnt_d;

  // The counter keeps stepping until its registered value reaches the
  // terminal value; the cycle it matches is the last RUN cycle of the pass.
  logic run_step;
  logic wrap_hit;
  assign run_step = (ctr_q != end_q);
  assign wrap_hit = up_q ? ctr_max_tick : ctr_min_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      start_q    <= '0;
      end_q      <= '0;
      up_q       <= 1'b0;
      reps_q     <= '0;
      wrapped_q  <= 1'b0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      end_q      <= end_d;
      up_q       <= up_d;
      reps_q     <= reps_d;
      wrapped_q  <= wrapped_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    end_d      = end_q;
    up_d       = up_q;
    reps_d     = reps_q;
    wrapped_d  = wrapped_q;
    pass_cnt_d = pass_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          start_d    = cmd_start;
          end_d      = cmd_end;
          up_d       = cmd_up;
          reps_d     = cmd_reps;
          wrapped_d  = 1'b0;
          pass_cnt_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = abort ? S_ABORT : S_RUN;
      end
      S_RUN: begin
        // A wrapping step is still taken by the counter even if abort
        // arrives in the same cycle, so the flag is recorded regardless.
        if (run_step && wrap_hit) begin
          wrapped_d = 1'b1;
        end
        if (abort) begin
          state_d = S_ABORT;
        end else if (!run_step) begin
          if (pass_cnt_q != 4'hF) begin
            pass_cnt_d = pass_cnt_q + 4'd1;
          end
          if (reps_q == 4'd0) begin
            state_d = S_DONE;
          end else begin
            reps_d  = reps_q - 4'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    ctr_syn_clr = 1'b0;
    ctr_load    = 1'b0;
    ctr_en      = 1'b0;
    ctr_up      = 1'b0;
    ctr_d       = '0;
    done        = 1'b0;
    aborted     = 1'b0;
    case (state_q)
      S_IDLE: cmd_ready = 1'b1;
      S_LOAD: begin
        busy     = 1'b1;
        ctr_load = 1'b1;
        ctr_d    = start_q;
      end
      S_RUN: begin
        busy   = 1'b1;
        ctr_up = up_q;
        ctr_en = run_step;
      end
      S_DONE: done = 1'b1;
      S_ABORT: begin
        ctr_syn_clr = 1'b1;
        aborted     = 1'b1;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  assign wrapped  = wrapped_q;
  assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb/tb_count_seq_ctrl.sv - self-checking bench for count_seq_ctrl
module tb_count_seq_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [N-1:0] cmd_start = '0;
  logic [N-1:0] cmd_end = '0;
  logic         cmd_up = 1'b0;
  logic [3:0]   cmd_reps = '0;
  logic         abort = 1'b0;
  logic         ctr_syn_clr, ctr_load, ctr_en, ctr_up;
  logic [N-1:0] ctr_d;
  logic [N-1:0] ctr_q;
  logic         ctr_max_tick, ctr_min_tick;
  logic         busy, done, aborted, wrapped;
  logic [3:0]   pass_cnt;

  count_seq_ctrl #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_up(cmd_up), .cmd_reps(cmd_reps),
    .abort(abort),
    .ctr_syn_clr(ctr_syn_clr), .ctr_load(ctr_load), .ctr_en(ctr_en), .ctr_up(ctr_up),
    .ctr_d(ctr_d), .ctr_q(ctr_q), .ctr_max_tick(ctr_max_tick), .ctr_min_tick(ctr_min_tick),
    .busy(busy), .done(done), .aborted(aborted), .wrapped(wrapped), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  // External universal counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            ctr_q <= '0;
    else if (ctr_syn_clr) ctr_q <= '0;
    else if (ctr_load)    ctr_q <= ctr_d;
    else if (ctr_en)      ctr_q <= ctr_up ? ctr_q + 8'd1 : ctr_q - 8'd1;
  end
  assign ctr_max_tick = (ctr_q == 8'hFF);
  assign ctr_min_tick = (ctr_q == 8'h00);

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected per-cycle outputs
  typedef struct {
    bit ready, busy, load, en, up, clr, done, abrt, qv, act, w;
    int d, q, pc;
  } rec_t;

  rec_t exp_q[$];
  int   idle_pc = 0;
  bit   idle_w = 1'b0;

  function automatic rec_t base_rec();
    rec_t r;
    r.ready = 0; r.busy = 0; r.load = 0; r.en = 0; r.up = 0; r.clr = 0;
    r.done = 0; r.abrt = 0; r.qv = 0; r.act = 0; r.w = 0;
    r.d = 0; r.q = 0; r.pc = 0;
    return r;
  endfunction

  function automatic rec_t idle_rec();
    rec_t r = base_rec();
    r.ready = 1; r.pc = idle_pc; r.w = idle_w;
    return r;
  endfunction

  // Expand a command into its whole cycle-by-cycle expectation.
  task automatic gen(input int s, input int e, input bit u, input int reps);
    int  pc = 0;
    bit  w = 0;
    int  steps, q;
    rec_t x;
    for (int p = 0; p <= reps; p++) begin
      x = base_rec(); x.busy = 1; x.load = 1; x.d = s; x.act = 1; x.pc = pc; x.w = w;
      exp_q.push_back(x);
      steps = u ? ((e - s) & 255) : ((s - e) & 255);
      for (int k = 0; k <= steps; k++) begin
        q = u ? ((s + k) & 255) : ((s - k) & 255);
        x = base_rec(); x.busy = 1; x.up = u; x.en = (k < steps); x.q = q; x.qv = 1;
        x.act = 1; x.pc = pc; x.w = w;
        exp_q.push_back(x);
        if (x.en && ((u && q == 255) || (!u && q == 0))) w = 1;
      end
      pc = (pc < 15) ? pc + 1 : 15;
    end
    x = base_rec(); x.done = 1; x.pc = pc; x.w = w;
    exp_q.push_back(x);
    idle_pc = pc;
    idle_w  = w;
  endtask

  always @(negedge clk) begin
    rec_t cur, x;
    bit   wn;
    if (reset) begin
      exp_q.delete(); idle_pc = 0; idle_w = 0;
      cur = idle_rec();
    end else if (exp_q.size() == 0) begin
      cur = idle_rec();
      if (cmd_valid) gen(int'(cmd_start), int'(cmd_end), cmd_up, int'(cmd_reps));
    end else begin
      cur = exp_q.pop_front();
    end
    chk("cmd_ready", cmd_ready, cur.ready);
    chk("busy", busy, cur.busy);
    chk("ctr_load", ctr_load, cur.load);
    chk("ctr_en", ctr_en, cur.en);
    chk("ctr_up", ctr_up, cur.up);
    chk("ctr_syn_clr", ctr_syn_clr, cur.clr);
    chk("ctr_d", ctr_d, cur.d);
    chk("done", done, cur.done);
    chk("aborted", aborted, cur.abrt);
    chk("pass_cnt", pass_cnt, cur.pc);
    chk("wrapped", wrapped, cur.w);
    if (cur.qv) chk("ctr_q", ctr_q, cur.q);
    if (!reset && cur.act && abort) begin
      wn = cur.w | (cur.en && ((cur.up && cur.q == 255) || (!cur.up && cur.q == 0)));
      exp_q.delete();
      x = base_rec(); x.clr = 1; x.abrt = 1; x.pc = cur.pc; x.w = wn;
      exp_q.push_back(x);
      idle_pc = cur.pc; idle_w = wn;
    end
  end

  // Event monitor
  int n_load = 0, n_done = 0, n_abort = 0;
  int done_cyc = 0, hs_cyc = 0, hs_prev = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (ctr_load) n_load++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (aborted) n_abort++;
      if (cmd_valid && cmd_ready) begin hs_prev = hs_cyc; hs_cyc = cyc; end
    end
  end

  task automatic send(input int s, input int e, input bit u, input int r);
    bit ok = 0;
    cmd_start = 8'(s); cmd_end = 8'(e); cmd_up = u; cmd_reps = 4'(r); cmd_valid = 1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    if (!ok) begin bad++; total++; $display("FAIL send_timeout: got no cmd_ready, required 1"); end
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_end();
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (done || aborted) ok = 1;
    end
    if (!ok) begin bad++; total++; $display("FAIL end_timeout: got no done/aborted, required pulse"); end
    @(posedge clk); #1;
  endtask

  int l0, d0, a0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    reset = 0;
    @(posedge clk); #1;

    // basic up count 3..6
    l0 = n_load; d0 = n_done;
    send(3, 6, 1, 0);
    wait_end();
    chk("t1_latency", done_cyc - hs_cyc, 6);
    chk("t1_pass_cnt", pass_cnt, 1);
    chk("t1_wrapped", wrapped, 0);
    chk("t1_ready", cmd_ready, 1);
    chk("t1_loads", n_load - l0, 1);

    // up wrap 254..1
    send(254, 1, 1, 0);
    wait_end();
    chk("t2_latency", done_cyc - hs_cyc, 6);
    chk("t2_wrapped", wrapped, 1);

    // down, three passes
    l0 = n_load; d0 = n_done;
    send(5, 2, 0, 2);
    wait_end();
    chk("t3_loads", n_load - l0, 3);
    chk("t3_dones", n_done - d0, 1);
    chk("t3_pass_cnt", pass_cnt, 3);
    chk("t3_wrapped", wrapped, 0);
    chk("t3_latency", done_cyc - hs_cyc, 16);

    // zero-step pass
    send(7, 7, 1, 0);
    wait_end();
    chk("t4_latency", done_cyc - hs_cyc, 3);
    chk("t4_pass_cnt", pass_cnt, 1);

    // down wrap 1..254
    send(1, 254, 0, 0);
    wait_end();
    chk("t5_wrapped", wrapped, 1);
    chk("t5_latency", done_cyc - hs_cyc, 6);

    // pass count saturation
    send(9, 9, 0, 15);
    wait_end();
    chk("t6_pass_cnt", pass_cnt, 15);
    chk("t6_latency", done_cyc - hs_cyc, 33);

    // abort at end of first pass
    d0 = n_done; a0 = n_abort;
    send(10, 12, 1, 1);
    repeat (3) @(posedge clk);
    #1 abort = 1;
    @(negedge clk);
    chk("t7_q_at_end", ctr_q, 12);
    @(posedge clk); #1;
    abort = 0;
    chk("t7_clr", ctr_syn_clr, 1);
    chk("t7_aborted", aborted, 1);
    chk("t7_done", done, 0);
    @(posedge clk); #1;
    chk("t7_ready", cmd_ready, 1);
    chk("t7_pass_cnt", pass_cnt, 0);
    chk("t7_dones", n_done - d0, 0);
    chk("t7_aborts", n_abort - a0, 1);

    // abort while idle is ignored
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("t7_idle_abort", aborted, 0);
    chk("t7_idle_ready", cmd_ready, 1);

    // reset during RUN
    d0 = n_done; a0 = n_abort;
    send(0, 200, 1, 0);
    repeat (5) @(posedge clk);
    #3 reset = 1;
    #1;
    chk("t8_busy", busy, 0);
    chk("t8_en", ctr_en, 0);
    chk("t8_ready", cmd_ready, 1);
    chk("t8_pass_cnt", pass_cnt, 0);
    @(posedge clk); #1;
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t8_dones", n_done - d0, 0);
    chk("t8_aborts", n_abort - a0, 0);

    // command held valid while busy is taken only after returning to idle
    l0 = n_load;
    send(1, 3, 1, 0);
    cmd_start = 8'd20; cmd_end = 8'd18; cmd_up = 0; cmd_reps = 4'd0; cmd_valid = 1;
    begin
      bit ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if (cmd_ready) ok = 1;
      end
      if (!ok) begin bad++; total++; $display("FAIL t9_timeout: got no second handshake, required one"); end
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    chk("t9_hs_gap", hs_cyc - hs_prev, 6);
    wait_end();
    chk("t9_loads", n_load - l0, 2);
    chk("t9_pass_cnt", pass_cnt, 1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1);
  end

endmodule
